// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// Direct-mapped branch target buffer with a saturating direction counter per
// entry. Fetch looks it up combinationally to pick the next PC. Execute trains
// it with resolved control-transfer outcomes. It also flags mispredictions so
// the hazard unit can flush the younger pipeline stages.
//
// Optional feature macro: BPRED_STATS_EN
//   defined   -> 32-bit saturating counters of update cycles and mispredict cycles
//   undefined -> no counter registers; both stat ports read 0
//
// Parameters:
//   ENTRIES : number of BTB entries (power of two, 2..256)
//   CTR_W   : direction counter width (1..4)
//
// Ports:
//   CLK                 in   clock, rising edge
//   nRST                in   asynchronous active-low reset
//   lookup_pc[31:0]     in   PC being fetched
//   pred_hit            out  valid entry whose tag matches lookup_pc
//   pred_taken          out  pred_hit && counter MSB
//   pred_target[31:0]   out  entry target if predicted taken, else lookup_pc+4
//   update_en           in   a resolved branch/jump is being trained this cycle
//   update_pc[31:0]     in   PC of the resolving instruction
//   update_taken        in   actual outcome
//   update_target[31:0] in   actual target
//   update_pred_taken   in   prediction that travelled with the instruction
//   update_pred_target  in   predicted target that travelled with it
//   mispredict          out  update_en && prediction was wrong
//   stat_updates[31:0]  out  count of update_en cycles
//   stat_mispredicts    out  count of mispredict cycles
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] lookup_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        update_en,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    input  logic        update_pred_taken,
    input  logic [31:0] update_pred_target,
    output logic        mispredict,
    output logic [31:0] stat_updates,
    output logic [31:0] stat_mispredicts
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    // Counter encodings: allocate weakly taken, reset weakly not-taken.
    localparam logic [CTR_W-1:0] CTR_MAX   = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_ALLOC = CTR_W'(1 << (CTR_W - 1));
    localparam logic [CTR_W-1:0] CTR_RST   = CTR_W'((1 << (CTR_W - 1)) - 1);

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];
    logic [CTR_W-1:0] r_ctr    [ENTRIES];

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic             w_wr_en;
    logic [CTR_W-1:0] w_wr_ctr;
    logic [31:0]      w_wr_target;
    logic             w_unused;

    // Byte offset of the PC is irrelevant to word-aligned instructions.
    assign w_unused = ^{lookup_pc[1:0], update_pc[1:0]};

    // ------------------------------------------------------------------
    // Lookup: purely combinational, sees pre-update state (no bypass).
    // ------------------------------------------------------------------
    assign w_lk_idx    = lookup_pc[IDX_W+1:2];
    assign w_lk_tag    = lookup_pc[31:IDX_W+2];
    assign pred_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign pred_taken  = pred_hit && r_ctr[w_lk_idx][CTR_W-1];
    assign pred_target = pred_taken ? r_target[w_lk_idx] : (lookup_pc + 32'd4);

    // ------------------------------------------------------------------
    // Misprediction: wrong direction, or taken with the wrong target.
    // ------------------------------------------------------------------
    assign mispredict = update_en &&
                        ((update_taken != update_pred_taken) ||
                         (update_taken && (update_target != update_pred_target)));

    // ------------------------------------------------------------------
    // Training: compute the new contents of the indexed entry.
    // ------------------------------------------------------------------
    assign w_up_idx = update_pc[IDX_W+1:2];
    assign w_up_tag = update_pc[31:IDX_W+2];
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_ctr    = r_ctr[w_up_idx];
        w_wr_target = r_target[w_up_idx];
        if (update_en) begin
            if (w_up_hit) begin
                w_wr_en = 1'b1;
                if (update_taken) begin
                    if (r_ctr[w_up_idx] != CTR_MAX) begin
                        w_wr_ctr = r_ctr[w_up_idx] + 1'b1;
                    end
                    w_wr_target = update_target;
                end else if (r_ctr[w_up_idx] != '0) begin
                    w_wr_ctr = r_ctr[w_up_idx] - 1'b1;
                end
            end else if (update_taken) begin
                // Miss on a taken transfer: evict whatever lives here.
                w_wr_en     = 1'b1;
                w_wr_ctr    = CTR_ALLOC;
                w_wr_target = update_target;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= CTR_RST;
            end
        end else if (w_wr_en) begin
            r_valid[w_up_idx]  <= 1'b1;
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= w_wr_target;
            r_ctr[w_up_idx]    <= w_wr_ctr;
        end
    end

    // ------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------
`ifdef BPRED_STATS_EN
    logic [31:0] r_stat_updates;
    logic [31:0] r_stat_mispredicts;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stat_updates     <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (update_en && (r_stat_updates != 32'hFFFF_FFFF)) begin
                r_stat_updates <= r_stat_updates + 32'd1;
            end
            if (mispredict && (r_stat_mispredicts != 32'hFFFF_FFFF)) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end
        end
    end

    assign stat_updates     = r_stat_updates;
    assign stat_mispredicts = r_stat_mispredicts;
`else
    assign stat_updates     = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
//
// Directed testbench for branch_predictor (ENTRIES=16, CTR_W=2). Inputs are
// driven just after the falling clock edge and outputs are sampled 1 time
// unit later, well away from the training (rising) edge.
// ---------------------------------------------------------------------------
module tb_branch_predictor;
    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] lookup_pc = 32'd0;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        update_en = 1'b0;
    logic [31:0] update_pc = 32'd0;
    logic        update_taken = 1'b0;
    logic [31:0] update_target = 32'd0;
    logic        update_pred_taken = 1'b0;
    logic [31:0] update_pred_target = 32'd0;
    logic        mispredict;
    logic [31:0] stat_updates;
    logic [31:0] stat_mispredicts;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    branch_predictor #(.ENTRIES(16), .CTR_W(2)) dut (
        .CLK                (CLK),
        .nRST               (nRST),
        .lookup_pc          (lookup_pc),
        .pred_hit           (pred_hit),
        .pred_taken         (pred_taken),
        .pred_target        (pred_target),
        .update_en          (update_en),
        .update_pc          (update_pc),
        .update_taken       (update_taken),
        .update_target      (update_target),
        .update_pred_taken  (update_pred_taken),
        .update_pred_target (update_pred_target),
        .mispredict         (mispredict),
        .stat_updates       (stat_updates),
        .stat_mispredicts   (stat_mispredicts)
    );

    // Drive an update request; outputs settle 1 unit later.
    task automatic drive_update(input logic [31:0] pc, input logic tk,
                                input logic [31:0] tgt, input logic ptk,
                                input logic [31:0] ptgt);
        update_en          = 1'b1;
        update_pc          = pc;
        update_taken       = tk;
        update_target      = tgt;
        update_pred_taken  = ptk;
        update_pred_target = ptgt;
        #1;
    endtask

    // Let the training edge pass, then drop update_en at the falling edge.
    task automatic finish_update();
        @(negedge CLK);
        update_en = 1'b0;
        #1;
    endtask

    task automatic set_lookup(input logic [31:0] pc);
        lookup_pc = pc;
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        update_en = 1'b0;
        set_lookup(32'h40);
        checks++;
        if (pred_hit !== 1'b0 || pred_taken !== 1'b0 || pred_target !== 32'h44) begin
            errors++;
            $display("FAIL reset_lookup hit=%b taken=%b target=%h required 0 0 00000044",
                     pred_hit, pred_taken, pred_target);
        end
        checks++;
        if (mispredict !== 1'b0 || stat_updates !== 32'd0 || stat_mispredicts !== 32'd0) begin
            errors++;
            $display("FAIL reset_misc mispredict=%b upd=%0d mis=%0d required 0 0 0",
                     mispredict, stat_updates, stat_mispredicts);
        end
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        #1;
        checks++;
        if (pred_hit !== 1'b0 || pred_target !== 32'h44) begin
            errors++;
            $display("FAIL reset_stable hit=%b target=%h required 0 00000044", pred_hit, pred_target);
        end
        $display("test_reset done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_alloc();
        set_lookup(32'h40);
        drive_update(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        checks++;
        if (mispredict !== 1'b1) begin
            errors++;
            $display("FAIL alloc_mispredict got=%b required 1", mispredict);
        end
        finish_update();
        checks++;
        if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h100) begin
            errors++;
            $display("FAIL alloc_lookup hit=%b taken=%b target=%h required 1 1 00000100",
                     pred_hit, pred_taken, pred_target);
        end
        checks++;
        if (mispredict !== 1'b0) begin
            errors++;
            $display("FAIL idle_mispredict got=%b required 0", mispredict);
        end
        // Byte offset ignored on lookup
        set_lookup(32'h42);
        checks++;
        if (pred_hit !== 1'b1 || pred_target !== 32'h100) begin
            errors++;
            $display("FAIL offset_lookup hit=%b target=%h required 1 00000100", pred_hit, pred_target);
        end
        set_lookup(32'h40);
        $display("test_alloc done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_counter();
        // Two more taken, correctly predicted: ctr 2 -> 3 -> 3 (saturate high)
        for (int i = 0; i < 2; i++) begin
            drive_update(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
            checks++;
            if (mispredict !== 1'b0) begin
                errors++;
                $display("FAIL taken_correct_%0d mispredict=%b required 0", i, mispredict);
            end
            finish_update();
        end
        // First not-taken: ctr 3 -> 2, still predicted taken
        drive_update(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
        checks++;
        if (mispredict !== 1'b1) begin
            errors++;
            $display("FAIL nt1_mispredict got=%b required 1", mispredict);
        end
        finish_update();
        checks++;
        if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h100) begin
            errors++;
            $display("FAIL nt1_lookup hit=%b taken=%b target=%h required 1 1 00000100",
                     pred_hit, pred_taken, pred_target);
        end
        // Second not-taken: ctr 2 -> 1, predicted not taken, entry still valid
        drive_update(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
        finish_update();
        checks++;
        if (pred_hit !== 1'b1 || pred_taken !== 1'b0 || pred_target !== 32'h44) begin
            errors++;
            $display("FAIL nt2_lookup hit=%b taken=%b target=%h required 1 0 00000044",
                     pred_hit, pred_taken, pred_target);
        end
        // Two more not-taken, correctly predicted: ctr 1 -> 0 -> 0 (saturate low)
        for (int i = 0; i < 2; i++) begin
            drive_update(32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
            checks++;
            if (mispredict !== 1'b0) begin
                errors++;
                $display("FAIL nt_correct_%0d mispredict=%b required 0", i, mispredict);
            end
            finish_update();
        end
        // One taken with a new target: ctr 0 -> 1, still predicted not taken
        drive_update(32'h40, 1'b1, 32'h180, 1'b0, 32'h0);
        finish_update();
        checks++;
        if (pred_hit !== 1'b1 || pred_taken !== 1'b0 || pred_target !== 32'h44) begin
            errors++;
            $display("FAIL sat_low_lookup hit=%b taken=%b target=%h required 1 0 00000044",
                     pred_hit, pred_taken, pred_target);
        end
        // Taken again: ctr 1 -> 2, target was updated to 0x180 on the previous hit
        drive_update(32'h40, 1'b1, 32'h180, 1'b0, 32'h0);
        finish_update();
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h180) begin
            errors++;
            $display("FAIL retarget_lookup taken=%b target=%h required 1 00000180",
                     pred_taken, pred_target);
        end
        // Direction right but target wrong still counts as a mispredict
        drive_update(32'h40, 1'b1, 32'h180, 1'b1, 32'h100);
        checks++;
        if (mispredict !== 1'b1) begin
            errors++;
            $display("FAIL target_mispredict got=%b required 1", mispredict);
        end
        finish_update();
        $display("test_counter done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_alias();
        // 0x440 shares index 0 with 0x40 but has a different tag
        drive_update(32'h440, 1'b1, 32'h200, 1'b0, 32'h0);
        finish_update();
        set_lookup(32'h40);
        checks++;
        if (pred_hit !== 1'b0 || pred_target !== 32'h44) begin
            errors++;
            $display("FAIL alias_old hit=%b target=%h required 0 00000044", pred_hit, pred_target);
        end
        set_lookup(32'h440);
        checks++;
        if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h200) begin
            errors++;
            $display("FAIL alias_new hit=%b taken=%b target=%h required 1 1 00000200",
                     pred_hit, pred_taken, pred_target);
        end
        // Miss + not taken does not allocate
        drive_update(32'hC0, 1'b0, 32'h0, 1'b0, 32'h0);
        finish_update();
        set_lookup(32'hC0);
        checks++;
        if (pred_hit !== 1'b0 || pred_target !== 32'hC4) begin
            errors++;
            $display("FAIL miss_nt hit=%b target=%h required 0 000000c4", pred_hit, pred_target);
        end
        $display("test_alias done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_same_cycle();
        set_lookup(32'h80);
        drive_update(32'h80, 1'b1, 32'h300, 1'b0, 32'h0);
        checks++;
        if (pred_hit !== 1'b0 || pred_target !== 32'h84) begin
            errors++;
            $display("FAIL same_cycle_pre hit=%b target=%h required 0 00000084", pred_hit, pred_target);
        end
        finish_update();
        checks++;
        if (pred_hit !== 1'b1 || pred_target !== 32'h300) begin
            errors++;
            $display("FAIL same_cycle_post hit=%b target=%h required 1 00000300", pred_hit, pred_target);
        end
        set_lookup(32'hFFFF_FFFC);
        checks++;
        if (pred_hit !== 1'b0 || pred_target !== 32'h0) begin
            errors++;
            $display("FAIL pc_wrap hit=%b target=%h required 0 00000000", pred_hit, pred_target);
        end
        $display("test_same_cycle done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_reset_mid_update();
        drive_update(32'h100, 1'b1, 32'h500, 1'b0, 32'h0);
        nRST = 1'b0;
        #1;
        set_lookup(32'h80);
        checks++;
        if (pred_hit !== 1'b0) begin
            errors++;
            $display("FAIL async_clear hit=%b required 0", pred_hit);
        end
        finish_update();
        nRST = 1'b1;
        @(negedge CLK);
        #1;
        set_lookup(32'h100);
        checks++;
        if (pred_hit !== 1'b0 || pred_target !== 32'h104) begin
            errors++;
            $display("FAIL mid_update_discard hit=%b target=%h required 0 00000104",
                     pred_hit, pred_target);
        end
        $display("test_reset_mid_update done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_stats();
        logic [31:0] exp_upd;
        logic [31:0] exp_mis;
        // Five updates, mispredicts on #1 and #4
        drive_update(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);   finish_update();
        drive_update(32'h40, 1'b1, 32'h100, 1'b1, 32'h100); finish_update();
        drive_update(32'hC0, 1'b0, 32'h0,   1'b0, 32'h0);   finish_update();
        drive_update(32'h40, 1'b0, 32'h0,   1'b1, 32'h100); finish_update();
        drive_update(32'h80, 1'b0, 32'h0,   1'b0, 32'h0);   finish_update();
`ifdef BPRED_STATS_EN
        exp_upd = 32'd5;
        exp_mis = 32'd2;
`else
        exp_upd = 32'd0;
        exp_mis = 32'd0;
`endif
        checks++;
        if (stat_updates !== exp_upd || stat_mispredicts !== exp_mis) begin
            errors++;
            $display("FAIL stats_count upd=%0d mis=%0d required %0d %0d",
                     stat_updates, stat_mispredicts, exp_upd, exp_mis);
        end
        nRST = 1'b0;
        #1;
        checks++;
        if (stat_updates !== 32'd0 || stat_mispredicts !== 32'd0) begin
            errors++;
            $display("FAIL stats_reset upd=%0d mis=%0d required 0 0", stat_updates, stat_mispredicts);
        end
        @(negedge CLK);
        nRST = 1'b1;
        $display("test_stats done checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_counter();
        test_alias();
        test_same_cycle();
        test_reset_mid_update();
        test_stats();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch target buffer with per-entry saturating direction counters, replacing the fixed predict-not-taken next-PC selection of the pipelined datapath. Fetch queries it combinationally with the current PC to choose the next PC. The execute stage trains it with resolved branch and jump outcomes. It also flags mispredictions so the hazard unit can flush IF/ID and ID/EX.

## Interface
Parameters:
- ENTRIES, 16: number of BTB entries; power of two, 2..256; IDX_W = log2(ENTRIES).
- CTR_W, 2: direction counter width, 1..4.

Ports (word_t = 32 bits, from cpu_types_pkg). One clock; reset is asynchronous and active-low (CLK, nRST).
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  asynchronous active-low reset.
- lookup_pc  in  32  PC of the instruction being fetched.
- pred_hit  out  1  a valid entry's tag matches lookup_pc.
- pred_taken  out  1  predicted taken; equals pred_hit && counter MSB.
- pred_target  out  32  entry target if pred_taken, else lookup_pc+4.
- update_en  in  1  EX holds a resolved control-transfer instruction and the pipeline is not stalled.
- update_pc  in  32  PC of the resolving instruction.
- update_taken  in  1  actual outcome.
- update_target  in  32  actual target (don't care when not taken).
- update_pred_taken  in  1  prediction carried down the pipe for this instruction.
- update_pred_target  in  32  predicted target carried down the pipe.
- mispredict  out  1  update_en && prediction wrong.
- stat_updates  out  32  count of update_en cycles (see Configuration).
- stat_mispredicts  out  32  count of mispredict cycles (see Configuration).

## Operation
- Entry fields: valid, tag = pc[31:IDX_W+2], target[31:0], ctr[CTR_W-1:0]; index = pc[IDX_W+1:2]; pc[1:0] ignored.
- Lookup is purely combinational from lookup_pc and current state.
- mispredict = update_en && ((update_taken != update_pred_taken) || (update_taken && update_target != update_pred_target)); combinational.
- Training on update_en, indexed by update_pc:
  - Hit, taken: ctr saturating-increments (stays at 2^CTR_W-1); target <= update_target.
  - Hit, not taken: ctr saturating-decrements (stays at 0); target unchanged; entry stays valid.
  - Miss, taken: allocate, overwriting any occupant. Set valid=1, tag, target, and ctr = 2^(CTR_W-1) (weakly taken).
  - Miss, not taken: no change.
- Counter arithmetic is unsigned CTR_W bits with no wrap. For CTR_W=1: hit-taken sets ctr=1, hit-not-taken sets ctr=0, and allocation sets ctr=1.
- No replacement policy beyond direct mapping; aliasing PCs with different tags evict each other.

## Timing
- Reset (nRST low, asynchronous): all valid=0, all ctr = 2^(CTR_W-1)-1 (weakly not-taken; 0 for CTR_W=1), targets=0, stats=0.
- Reset outputs: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4, mispredict=0.
- Lookup latency 0 cycles; update visible to lookup on the cycle after the training edge.
- A lookup and an update to the same index in the same cycle: the lookup returns pre-update state. No bypass.
- Reset asserted mid-update: the update is discarded and the table is cleared.
- update_en is sampled only at the rising edge; the caller gates it with stall. A stalled EX must hold update_en low to avoid double training.
- pred_target = lookup_pc+4 wraps modulo 2^32.

## Configuration
- BPRED_STATS_EN defined: stat_updates increments on each update_en cycle and stat_mispredicts on each mispredict cycle. Both are 32-bit, saturating at 32'hFFFFFFFF and cleared by nRST.
- BPRED_STATS_EN undefined: no counter registers; both stat ports are tied to 0. Prediction behaviour is identical in both builds.

## Test plan
- Reset, then lookup_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0x44; all outputs stable.
- Update pc=0x40, taken, target=0x100, pred_taken=0 -> mispredict=1 that cycle. Next cycle lookup 0x40 -> pred_hit=1, pred_taken=1, pred_target=0x100.
- CTR_W=2, trained entry at 0x40 with three taken updates: one not-taken keeps pred_taken=1 and mispredict=1; a second not-taken gives pred_taken=0 and pred_target=0x44.
- ENTRIES=16, allocate 0x40 then a taken update to 0x440 (same index, different tag) -> lookup 0x40 gives pred_hit=0; lookup 0x440 gives hit with the new target.
- Same-cycle lookup and update at 0x80 (first allocation) -> lookup that cycle reports pred_hit=0; following cycle pred_hit=1.
- With BPRED_STATS_EN: 5 updates including 2 mispredicts -> stat_updates=5, stat_mispredicts=2; assert nRST -> both 0. Without the macro both read 0 throughout.
